// File: rtl/mem_bus_arbiter.sv
// MiniMIPS32 external memory port arbiter: shares one req/ack bus
// between instruction fetch and the MEM stage, with watchdog abort.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_ce,
  input  logic        dm_we,
  input  logic [3:0]  dm_sel,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  input  logic        dm_exc,
  input  logic        flush,
  output logic        stall_req,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE, DATA, INST, DONE
  } state_e;

  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          stall_q, stall_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drop_q, drop_d;

  logic tmo;
  logic drop_now;
  logic [31:0] rd;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    err_d      = 1'b0;
    tmo        = (TIMEOUT != 0) && (cnt_q == TMO);
    drop_now   = drop_q || ((state_q == INST) && flush);
    rd         = bus_ack ? bus_rdata : 32'h0;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        drop_d = 1'b0;
        if (dm_ce && !dm_exc) begin
          we_d    = dm_we;
          sel_d   = dm_sel;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          req_d   = 1'b1;
          state_d = DATA;
        end else if (if_req) begin
          we_d    = 1'b0;
          sel_d   = 4'b1111;
          addr_d  = if_addr;
          req_d   = 1'b1;
          state_d = INST;
        end
      end
      DATA, INST: begin
        drop_d = drop_now;
        // ack beats a coincident watchdog expiry
        if (bus_ack || tmo) begin
          req_d   = 1'b0;
          err_d   = !bus_ack;
          state_d = DONE;
          if (state_q == DATA) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = rd;
          end else if (!drop_now) begin
            if_ack_d   = 1'b1;
            if_rdata_d = rd;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        drop_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // data stall spans grant through the dm_ack cycle
    stall_d = (state_d == DATA) || dm_ack_d ||
              (dm_ce && !dm_exc && !dm_ack_q && !dm_ack_d) ||
              (if_req && !if_ack_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'b0000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_sel   = sel_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_req = stall_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: bus responder model,
// ack scoreboard, burst monitor and stall watcher.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_ce = 1'b0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_sel = 4'h0;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_exc = 1'b0;
  logic        flush = 1'b0;
  logic        stall_req;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(TMO), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_ce(dm_ce), .dm_we(dm_we), .dm_sel(dm_sel),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .dm_exc(dm_exc), .flush(flush),
    .stall_req(stall_req), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        dm;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } burst_t;

  exp_t   sbq[$];
  burst_t bq[$];

  int n_tests = 0;
  int n_fail  = 0;

  int  ack_delay = 0;
  int  wcnt = 0;
  int  gap = 0;
  bit  seen = 0;
  bit  chk_stall = 0;
  logic prev_req = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] resp(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h2408_0001;
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(negedge clk) begin
    exp_t   e;
    burst_t b;
    if (if_ack || dm_ack) begin
      check("sb_pending", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("ack_kind", 32'(dm_ack), 32'(e.dm));
        check("ack_single", 32'(if_ack & dm_ack), 32'd0);
        check("ack_rdata", e.dm ? dm_rdata : if_rdata, e.rdata);
        check("ack_err", 32'(bus_err), 32'(e.err));
      end
    end
    if (bus_req && !prev_req) begin
      if (seen) check("bus_gap", 32'(gap >= 1), 32'd1);
      b.we = bus_we; b.sel = bus_sel; b.addr = bus_addr;
      b.wdata = bus_wdata; b.len = 1;
      bq.push_back(b);
      seen = 1;
      gap = 0;
    end else if (bus_req) begin
      b = bq[bq.size()-1];
      check("frz_addr", bus_addr, b.addr);
      check("frz_ctl", {27'h0, bus_we, bus_sel}, {27'h0, b.we, b.sel});
      check("frz_wdata", bus_wdata, b.wdata);
      bq[bq.size()-1].len = b.len + 1;
    end else begin
      gap++;
    end
    prev_req = bus_req;
    if (chk_stall) begin
      check("stall_hold", 32'(stall_req), 32'd1);
      if (dm_ack) chk_stall = 0;
    end
    if (!rst) begin
      bus_ack = 1'b0; wcnt = 0;
    end else if (bus_ack) begin
      bus_ack = 1'b0; wcnt = 0;
    end else if (bus_req) begin
      if (ack_delay >= 0 && wcnt == ack_delay) begin
        bus_ack = 1'b1;
        bus_rdata = resp(bus_addr);
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag, input bit want_dm,
                          output int cyc);
    logic hit;
    hit = 1'b0;
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (want_dm ? dm_ack : if_ack) begin
        hit = 1'b1;
        cyc = i + 1;
        break;
      end
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"}, 32'(bus_req), 0);
    check({tag, "_we"}, 32'(bus_we), 0);
    check({tag, "_sel"}, 32'(bus_sel), 0);
    check({tag, "_addr"}, bus_addr, 0);
    check({tag, "_wdata"}, bus_wdata, 0);
    check({tag, "_acks"}, 32'({if_ack, dm_ack}), 0);
    check({tag, "_ird"}, if_rdata, 0);
    check({tag, "_drd"}, dm_rdata, 0);
    check({tag, "_stall"}, 32'(stall_req), 0);
    check({tag, "_err"}, 32'(bus_err), 0);
  endtask

  initial begin
    int cyc;
    logic [31:0] r0;

    #1 rst = 1'b0;
    tick(); tick();
    check_zero("reset");
    rst = 1'b1;
    tick();

    // single fetch, ack after 2 wait cycles
    bq.delete();
    ack_delay = 2;
    sbq.push_back('{1'b0, 32'h2408_0001, 1'b0});
    if_addr = 32'h0000_0100; if_req = 1'b1;
    wait_ack("fetch_ack", 1'b0, cyc);
    if_req = 1'b0;
    check("fetch_lat", 32'(cyc), 32'(ack_delay + 2));
    tick(); tick();
    check("fetch_idle", 32'(bus_req), 0);
    check("fetch_bursts", 32'(bq.size()), 1);
    check("fetch_addr", bq[0].addr, 32'h100);
    check("fetch_ctl", {27'h0, bq[0].we, bq[0].sel}, 32'h0F);
    check("fetch_rd_keep", if_rdata, 32'h2408_0001);

    // contention: data store wins over fetch
    bq.delete();
    ack_delay = 1;
    sbq.push_back('{1'b1, resp(32'h2004), 1'b0});
    sbq.push_back('{1'b0, resp(32'h200), 1'b0});
    if_addr = 32'h0000_0200; if_req = 1'b1;
    dm_ce = 1'b1; dm_we = 1'b1; dm_sel = 4'b1111;
    dm_addr = 32'h0000_2004; dm_wdata = 32'hDEAD_BEEF;
    tick();
    chk_stall = 1;
    wait_ack("cont_dm_ack", 1'b1, cyc);
    dm_ce = 1'b0; dm_we = 1'b0;
    wait_ack("cont_if_ack", 1'b0, cyc);
    if_req = 1'b0;
    tick(); tick();
    check("cont_bursts", 32'(bq.size()), 2);
    check("cont_b0_we", 32'(bq[0].we), 1);
    check("cont_b0_addr", bq[0].addr, 32'h2004);
    check("cont_b0_wd", bq[0].wdata, 32'hDEAD_BEEF);
    check("cont_b0_sel", 32'(bq[0].sel), 32'hF);
    check("cont_b1_we", 32'(bq[1].we), 0);
    check("cont_b1_addr", bq[1].addr, 32'h200);

    // load arriving one cycle into a fetch waits for it
    bq.delete();
    ack_delay = 2;
    sbq.push_back('{1'b0, resp(32'h300), 1'b0});
    if_addr = 32'h0000_0300; if_req = 1'b1;
    tick();
    sbq.push_back('{1'b1, resp(32'h400), 1'b0});
    dm_ce = 1'b1; dm_we = 1'b0; dm_sel = 4'b0011;
    dm_addr = 32'h0000_0400;
    chk_stall = 1;
    wait_ack("ld_if_ack", 1'b0, cyc);
    if_req = 1'b0;
    wait_ack("ld_dm_ack", 1'b1, cyc);
    dm_ce = 1'b0;
    tick(); tick();
    check("ld_bursts", 32'(bq.size()), 2);
    check("ld_b1_addr", bq[1].addr, 32'h400);
    check("ld_b1_sel", 32'(bq[1].sel), 32'h3);

    // flush in cycle 2 of a fetch: bus completes, no if_ack
    bq.delete();
    ack_delay = 3;
    r0 = if_rdata;
    if_addr = 32'h0000_0500; if_req = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; if_req = 1'b0;
    repeat (8) tick();
    check("fl_bursts", 32'(bq.size()), 1);
    check("fl_len", 32'(bq[0].len), 32'(ack_delay + 1));
    check("fl_rd_keep", if_rdata, r0);

    // watchdog abort on a load that is never acked
    bq.delete();
    ack_delay = -1;
    sbq.push_back('{1'b1, 32'h0, 1'b1});
    dm_ce = 1'b1; dm_we = 1'b0; dm_sel = 4'b1111;
    dm_addr = 32'h0000_0600;
    wait_ack("tmo_ack", 1'b1, cyc);
    dm_ce = 1'b0;
    tick(); tick();
    check("tmo_len", 32'(bq[0].len), 32'(TMO + 1));
    check("tmo_err_pulse", 32'(bus_err), 0);

    // ack coincides with counter == TIMEOUT: ack wins
    bq.delete();
    ack_delay = TMO;
    sbq.push_back('{1'b1, resp(32'h700), 1'b0});
    dm_ce = 1'b1; dm_addr = 32'h0000_0700;
    wait_ack("edge_ack", 1'b1, cyc);
    dm_ce = 1'b0;
    tick(); tick();
    check("edge_len", 32'(bq[0].len), 32'(TMO + 1));

    // asynchronous reset in the middle of a store
    bq.delete();
    ack_delay = -1;
    dm_ce = 1'b1; dm_we = 1'b1; dm_sel = 4'b1100;
    dm_addr = 32'h0000_0900; dm_wdata = 32'h1234_5678;
    tick(); tick();
    check("pre_rst_req", 32'(bus_req), 1);
    #2 rst = 1'b0;
    #1 check_zero("rst_mid");
    dm_ce = 1'b0; dm_we = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // first grant after reset, earliest possible ack
    bq.delete();
    ack_delay = 0;
    sbq.push_back('{1'b0, resp(32'h800), 1'b0});
    if_addr = 32'h0000_0800; if_req = 1'b1;
    wait_ack("post_rst_ack", 1'b0, cyc);
    if_req = 1'b0;
    check("post_rst_lat", 32'(cyc), 32'd2);
    tick(); tick();
    check("post_rst_addr", bq[0].addr, 32'h800);
    check("sb_drained", 32'(sbq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
